chess_clock_ctrl: RTL

//  Turn sequencer for the chess clock. Decides which player's time-counter

---
 rtl/chess_clock_pkg.sv | 16 +
 rtl/chess_clock_ctrl_btn_edge.sv | 43 ++++
 rtl/chess_clock_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/chess_clock_pkg.sv
// Shared state encoding for the chess clock turn sequencer.
package chess_clock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_A   = 3'd1,
    ST_RUN_B   = 3'd2,
    ST_PAUSE_A = 3'd3,
    ST_PAUSE_B = 3'd4,
    ST_FLAG_A  = 3'd5,
    ST_FLAG_B  = 3'd6
  } state_t;

endpackage

// File: rtl/chess_clock_ctrl_btn_edge.sv
// Front-panel button conditioner: 2-FF synchroniser plus rising-edge detector.
// An event needs the button seen low after reset, so a button held through reset stays silent.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_evt
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic vld_q,   vld_d;
  logic armed_q, armed_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    vld_d   = 1'b1;
    // sync1_q only holds a real sample once vld_q is set
    armed_d = armed_q | (vld_q & ~sync1_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
    end
  end

  assign btn_evt = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock turn sequencer: selects the running player chain, pause/resume,
// new-game clear, saturating full-move counter and sticky loss-on-time flags.
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              START,
  input  logic              BTN_A,
  input  logic              BTN_B,
  input  logic              PAUSE,
  input  logic              EXP_A,
  input  logic              EXP_B,
  output logic              EN_A,
  output logic              EN_B,
  output logic              CNT_CLR,
  output logic              ACTIVE,
  output logic [MOVE_W-1:0] MOVES,
  output logic              FLAG_A,
  output logic              FLAG_B,
  output logic [STATE_W-1:0] STATE
);

  logic start_evt, btn_a_evt, btn_b_evt, pause_evt;

  btn_edge u_start (.clk(CLK), .rst_n(CLR_N), .btn_raw(START), .btn_evt(start_evt));
  btn_edge u_btn_a (.clk(CLK), .rst_n(CLR_N), .btn_raw(BTN_A), .btn_evt(btn_a_evt));
  btn_edge u_btn_b (.clk(CLK), .rst_n(CLR_N), .btn_raw(BTN_B), .btn_evt(btn_b_evt));
  btn_edge u_pause (.clk(CLK), .rst_n(CLR_N), .btn_raw(PAUSE), .btn_evt(pause_evt));

  state_t            state_q, state_d;
  logic              active_q, active_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic              flag_a_q, flag_a_d;
  logic              flag_b_q, flag_b_d;
  logic              cnt_clr_q, cnt_clr_d;

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    moves_d   = moves_q;
    flag_a_d  = flag_a_q;
    flag_b_d  = flag_b_q;
    cnt_clr_d = 1'b0;

    // start outranks everything and always returns a live game to IDLE
    if (start_evt && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      active_d  = 1'b0;
      moves_d   = '0;
      flag_a_d  = 1'b0;
      flag_b_d  = 1'b0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_evt) begin
            state_d   = ST_RUN_A;
            active_d  = 1'b0;
            moves_d   = MOVE_W'(1);
            cnt_clr_d = 1'b1;
          end
        end
        ST_RUN_A: begin
          if (EXP_A) begin
            state_d  = ST_FLAG_A;
            flag_a_d = 1'b1;
          end else if (pause_evt) begin
            state_d = ST_PAUSE_A;
          end else if (btn_a_evt) begin
            state_d  = ST_RUN_B;
            active_d = 1'b1;
          end
        end
        ST_RUN_B: begin
          if (EXP_B) begin
            state_d  = ST_FLAG_B;
            flag_b_d = 1'b1;
          end else if (pause_evt) begin
            state_d = ST_PAUSE_B;
          end else if (btn_b_evt) begin
            state_d  = ST_RUN_A;
            active_d = 1'b0;
            if (moves_q != {MOVE_W{1'b1}}) moves_d = moves_q + MOVE_W'(1);
          end
        end
        ST_PAUSE_A: if (pause_evt) state_d = ST_RUN_A;
        ST_PAUSE_B: if (pause_evt) state_d = ST_RUN_B;
        ST_FLAG_A, ST_FLAG_B: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q   <= ST_IDLE;
      active_q  <= 1'b0;
      moves_q   <= '0;
      flag_a_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      moves_q   <= moves_d;
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign EN_A    = (state_q == ST_RUN_A);
  assign EN_B    = (state_q == ST_RUN_B);
  assign CNT_CLR = cnt_clr_q;
  assign ACTIVE  = active_q;
  assign MOVES   = moves_q;
  assign FLAG_A  = flag_a_q;
  assign FLAG_B  = flag_b_q;
  assign STATE   = state_q;

endmodule
